// File: rtl/fp_left_normalize_pkg.sv
// Shared FP datapath constants and types for the left normalizer.
package fp_pkg;

  localparam int IN_W   = 50;                 // unnormalized mantissa, bit IN_W-1 is the hidden one
  localparam int MANT_W = 23;                 // output fraction width
  localparam int EXP_W  = 8;                  // biased exponent width
  localparam int BIAS   = 127;
  localparam int LZ_W   = $clog2(IN_W + 1);   // leading-zero count 0..IN_W

  typedef logic [IN_W-1:0]   mant_in_t;
  typedef logic [EXP_W-1:0]  exp_t;
  typedef logic [LZ_W-1:0]   lz_t;
  typedef logic [MANT_W-1:0] frac_t;

  typedef struct packed {
    frac_t mant;
    exp_t  exp;
    logic  guard;
    logic  sticky;
    logic  zero;
  } norm_res_t;

  // Left-shift amount: full leading-zero count, but never push the exponent
  // below 1. An exponent of 0 is already denormal and is not shifted at all.
  // e-1 cannot wrap because the e==0 case is handled first.
  function automatic exp_t norm_shift(lz_t lz, exp_t e);
    exp_t lz_e;
    lz_e = exp_t'(lz);
    if (e == '0)
      return '0;
    else if (lz_e < e - exp_t'(1))
      return lz_e;
    else
      return e - exp_t'(1);
  endfunction

endpackage

// File: rtl/fp_left_normalize_if.sv
// Upstream/downstream valid-ready bundle of the left normalizer.
// master = the environment feeding and draining the block, slave = the block.
interface fp_left_normalize_if;
  import fp_pkg::*;

  logic  in_valid;
  logic  in_ready;
  mant_in_t in_mant;
  exp_t  in_exp;

  logic  out_valid;
  logic  out_ready;
  frac_t out_mant;
  exp_t  out_exp;
  logic  out_guard;
  logic  out_sticky;
  logic  out_zero;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_guard, out_sticky, out_zero
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_guard, out_sticky, out_zero
  );

endinterface

// File: rtl/fp_left_normalize_lzc.sv
// Combinational leading-zero counter. cnt = W when the input is all zero.
module fp_lzc #(
  parameter int W     = 50,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  // Scan LSB->MSB so the highest set bit is the last one to win.
  always_comb begin
    cnt      = CNT_W'(W);
    all_zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt      = CNT_W'(W - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_left_normalize.sv
// Two-stage left normalizer: stage A captures the beat with its leading-zero
// count, stage B shifts, clamps at the denormal boundary and splits the
// result into fraction/guard/sticky for the rounder.
module fp_left_normalize
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fp_left_normalize_if.slave  bus
);

  // stage A state
  logic     a_valid_q, a_valid_d;
  mant_in_t a_mant_q,  a_mant_d;
  exp_t     a_exp_q,   a_exp_d;
  lz_t      a_lz_q,    a_lz_d;
  logic     a_zero_q,  a_zero_d;

  // stage B state (drives the outputs directly)
  logic      b_valid_q, b_valid_d;
  norm_res_t res_q,     res_d;

  logic      a_adv, b_adv, in_fire;
  lz_t       lz_in;
  logic      zero_in;
  exp_t      sh, exp_n;
  mant_in_t  m;
  norm_res_t nrm;

  fp_lzc #(.W(IN_W), .CNT_W(LZ_W)) u_lzc (
    .din      (bus.in_mant),
    .cnt      (lz_in),
    .all_zero (zero_in)
  );

  // Stall chain: a stage may move when the one below it is empty or moving.
  always_comb begin
    b_adv   = !b_valid_q || bus.out_ready;
    a_adv   = !a_valid_q || b_adv;
    in_fire = bus.in_valid && a_adv;
  end

  assign bus.in_ready = a_adv;

  // Stage A capture; data holds when nothing is accepted.
  always_comb begin
    a_valid_d = a_valid_q;
    a_mant_d  = a_mant_q;
    a_exp_d   = a_exp_q;
    a_lz_d    = a_lz_q;
    a_zero_d  = a_zero_q;
    if (a_adv) a_valid_d = in_fire;
    if (in_fire) begin
      a_mant_d = bus.in_mant;
      a_exp_d  = bus.in_exp;
      a_lz_d   = lz_in;
      a_zero_d = zero_in;
    end
  end

  // Shift/clamp of the stage A beat. If the clamp stopped short of the
  // leading one, the result is denormal and carries exponent 0.
  always_comb begin
    sh    = norm_shift(a_lz_q, a_exp_q);
    m     = a_mant_q << sh;
    exp_n = a_exp_q - sh;
    nrm   = '0;
    if (a_zero_q) begin
      nrm.zero = 1'b1;
    end else begin
      nrm.mant   = m[IN_W-2 -: MANT_W];
      nrm.guard  = m[IN_W-2-MANT_W];
      nrm.sticky = |m[IN_W-3-MANT_W:0];
      nrm.exp    = m[IN_W-1] ? exp_n : '0;
    end
  end

  // Stage B load; result registers only change when a new beat moves in,
  // so the outputs stay stable while stalled.
  always_comb begin
    b_valid_d = b_valid_q;
    res_d     = res_q;
    if (b_adv) b_valid_d = a_valid_q;
    if (b_adv && a_valid_q) res_d = nrm;
  end

  // Pipeline registers; reset drops any in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_mant_q  <= '0;
      a_exp_q   <= '0;
      a_lz_q    <= '0;
      a_zero_q  <= 1'b0;
      b_valid_q <= 1'b0;
      res_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_mant_q  <= a_mant_d;
      a_exp_q   <= a_exp_d;
      a_lz_q    <= a_lz_d;
      a_zero_q  <= a_zero_d;
      b_valid_q <= b_valid_d;
      res_q     <= res_d;
    end
  end

  assign bus.out_valid  = b_valid_q;
  assign bus.out_mant   = res_q.mant;
  assign bus.out_exp    = res_q.exp;
  assign bus.out_guard  = res_q.guard;
  assign bus.out_sticky = res_q.sticky;
  assign bus.out_zero   = res_q.zero;

endmodule

// File: tb/tb_fp_left_normalize.sv
// Bench for fp_left_normalize: directed corner beats, backpressure, reset
// mid-stream and a randomized run against a bit-at-a-time normalize model.
module tb_fp_left_normalize;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_left_normalize_if bus();

  fp_left_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_en   = 1'b0;
  bit   acc;
  logic [33:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [33:0] pack(bit z, logic [7:0] e, logic [22:0] m, bit g, bit s);
    return {z, e, m, g, s};
  endfunction

  // Reference: double the mantissa one bit at a time while the exponent can
  // still go down to 1; if the hidden bit is still clear, it is denormal.
  function automatic logic [33:0] model(logic [49:0] mant, logic [7:0] e_in);
    logic [49:0] mm;
    int e;
    mm = mant;
    e  = e_in;
    if (mant == 0) return pack(1'b1, 8'd0, 23'd0, 1'b0, 1'b0);
    if (e != 0)
      while (!mm[49] && e > 1) begin
        mm = mm << 1;
        e--;
      end
    if (!mm[49]) e = 0;
    return pack(1'b0, 8'(e), mm[48:26], mm[25], |mm[24:0]);
  endfunction

  function automatic logic [33:0] dut_out();
    return {bus.out_zero, bus.out_exp, bus.out_mant, bus.out_guard, bus.out_sticky};
  endfunction

  // One clock: drive at the falling edge, then observe both handshakes.
  task automatic step(input bit v, input logic [49:0] mant, input logic [7:0] e,
                      input bit ordy, input logic [33:0] expv, output bit accepted);
    int a;
    @(negedge clk);
    cyc++;
    bus.in_valid  = v;
    bus.in_mant   = mant;
    bus.in_exp    = e;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", bus.out_valid, 0);
      else if (ordy) begin
        chk("result", dut_out(), exp_q.pop_front());
        a = acc_q.pop_front();
        if (lat_en) chk("latency", cyc - a, 2);
      end else chk("hold", dut_out(), exp_q[0]);
    end
    accepted = v && bus.in_ready;
    if (accepted) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic dir(input logic [49:0] mant, input logic [7:0] e, input logic [33:0] expv);
    bit a = 1'b0;
    for (int i = 0; i < 8 && !a; i++) step(1'b1, mant, e, 1'b1, expv, a);
    chk("dir_accept", a, 1);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, '0, a);
  endtask

  initial begin
    logic [63:0] r;
    logic [49:0] mant;
    logic [7:0]  e;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_exp = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_data", dut_out(), 0);

    // directed corners, unstalled, latency checked
    lat_en = 1'b1;
    dir(50'd1 << 45, 8'd130, pack(0, 8'd126, 23'd0, 0, 0));
    dir((50'd1 << 49) | (50'd1 << 26) | (50'd1 << 25) | 50'd1, 8'd100, pack(0, 8'd100, 23'h000001, 1, 1));
    dir(50'd1 << 40, 8'd5, pack(0, 8'd0, 23'h040000, 0, 0));
    dir(50'd1 << 30, 8'd0, pack(0, 8'd0, 23'h000010, 0, 0));
    dir(50'd0, 8'd77, pack(1, 8'd0, 23'd0, 0, 0));
    dir(50'd1, 8'd200, pack(0, 8'd151, 23'd0, 0, 0));
    dir(50'd1 << 10, 8'd1, pack(0, 8'd0, 23'd0, 0, 1));
    idle(4, 1'b1);
    lat_en = 1'b0;

    // backpressure: two beats fill the pipe, third waits for release
    step(1'b1, 50'h3_0000_0000_0001, 8'd20, 1'b0, model(50'h3_0000_0000_0001, 8'd20), acc);
    chk("bp_acc1", acc, 1);
    step(1'b1, 50'd1 << 3, 8'd60, 1'b0, model(50'd1 << 3, 8'd60), acc);
    chk("bp_acc2", acc, 1);
    step(1'b1, 50'h2_AAAA_5555_1234, 8'd9, 1'b0, model(50'h2_AAAA_5555_1234, 8'd9), acc);
    chk("bp_full_in_ready", acc, 0);
    step(1'b1, 50'h2_AAAA_5555_1234, 8'd9, 1'b0, model(50'h2_AAAA_5555_1234, 8'd9), acc);
    chk("bp_still_full", acc, 0);
    step(1'b1, 50'h2_AAAA_5555_1234, 8'd9, 1'b1, model(50'h2_AAAA_5555_1234, 8'd9), acc);
    chk("bp_release_acc", acc, 1);
    idle(4, 1'b1);
    chk("bp_drained", exp_q.size(), 0);

    // reset with two beats in flight
    step(1'b1, 50'd1 << 20, 8'd40, 1'b0, model(50'd1 << 20, 8'd40), acc);
    step(1'b1, 50'd1 << 21, 8'd41, 1'b0, model(50'd1 << 21, 8'd41), acc);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b1, '0, acc);
      chk("post_rst_no_stale", bus.out_valid, 0);
    end

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bit v, o;
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 7);
      r = {$urandom, $urandom};
      mant = r[49:0] >> $urandom_range(0, 50);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      step(v, mant, e, o, model(mant, e), acc);
    end
    idle(10, 1'b1);
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_left_normalize.md
Name: fp_left_normalize

Overview:
- Pipelined left-shift normalizer for the FP datapath, complementary to the multiplier's right shifter.
- Takes an unnormalized wide mantissa, for example an adder result after cancellation.
- Counts leading zeros, shifts left until the leading one sits at bit IN_W-1, and decrements the biased exponent.
- Clamps the shift at the denormal boundary; emits 23-bit mantissa plus guard/sticky to the rounder. Valid/ready on both sides; 2-cycle latency.

Parameters:
- IN_W, 50, input mantissa width; bit IN_W-1 is the hidden-one position.
- MANT_W, 23, output fraction width.
- EXP_W, 8, biased exponent width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mant  in  IN_W  unnormalized magnitude.
- in_exp  in  EXP_W  biased exponent corresponding to bit IN_W-1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  MANT_W  fraction bits below the leading one.
- out_exp  out  EXP_W  adjusted biased exponent.
- out_guard  out  1  first bit below out_mant.
- out_sticky  out  1  OR of all remaining lower bits.
- out_zero  out  1  input mantissa was all zero.

Behaviour:
- Reset: one clock; one synchronous active-high reset (clk, rst). On rst, both stage-valid flags clear.
  - out_valid=0; all out_* data registers = 0; in_ready=1 the cycle after reset deasserts.
  - Reset mid-operation discards in-flight beats; no partial output appears.
- Stage A (capture):
  - Load when in_valid && in_ready.
  - Registers in_mant, in_exp, and lz = leading-zero count of in_mant (0..IN_W, from sub-module).
- Stage B (shift):
  - sh = (in_exp==0) ? 0 : min(lz, in_exp-1).
  - m = in_mant << sh (IN_W bits, zero fill).
  - exp_n = in_exp - sh.
  - If m[IN_W-1]==0 after the shift, out_exp=0 (denormal); otherwise out_exp=exp_n.
  - out_mant = m[IN_W-2 -: MANT_W].
  - out_guard = m[IN_W-2-MANT_W].
  - out_sticky = |m[IN_W-3-MANT_W:0].
  - Zero input (lz==IN_W): out_mant=0, out_exp=0, guard=sticky=0, out_zero=1.
  - Exponent arithmetic is unsigned in EXP_W+1 bits; clamping guarantees no wrap.
- Pipeline control:
  - b_adv = !b_valid || out_ready.
  - a_adv = !a_valid || b_adv.
  - in_ready = a_adv (combinational; no combinational path from in_valid).
  - A moves to B when a_valid && b_adv.
  - Outputs held stable while out_valid && !out_ready.
- Latency: accepted beat appears on out_valid 2 cycles later if unstalled. Throughput 1 beat/cycle. Max 2 beats in flight.
- Simultaneous accept and drain in the same cycle is legal: both stages update, and order is preserved.

Decomposition:
- Package fp_pkg: IN_W, MANT_W, EXP_W, BIAS=127, and typedefs mant_in_t, exp_t, norm_res_t (struct of mant/exp/guard/sticky/zero).
- One sub-module: fp_lzc (combinational leading-zero counter, parameterized width, outputs count and all_zero).

Test Plan:
- Basic shift: in_mant = 1<<45, in_exp=130 -> lz=4, out_exp=126, out_mant=0, guard=0, sticky=0, out_valid exactly 2 cycles after accept.
- Already normalized: in_mant = (1<<49)|(1<<26)|(1<<25)|1, in_exp=100 -> out_exp=100, out_mant=23'h000001, guard=1, sticky=1.
- Denormal clamp: in_mant = 1<<40, in_exp=5 -> shift 4, out_exp=0, out_mant=23'h040000.
- Exponent-zero input: in_exp=0, any nonzero mantissa -> no shift, out_exp=0.
- Zero input: in_mant=0, in_exp=77 -> out_zero=1, out_mant=0, out_exp=0.
- Backpressure:
  - Hold out_ready=0 and drive 3 back-to-back beats -> 2 accepted, in_ready=0 on the third, outputs stable.
  - Release out_ready -> results emerge in order, third beat accepted the same cycle.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 on the next edge, and no stale beats emerge afterwards.
